ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side end of the cache↔RAM handshake. It answers the cache controller's RAMreadEnable/RAMwriteEnable strobes with a backing word array.
- Completes each read with a one-cycle dataReady pulse after a configurable latency.
- Buffers one request that arrives while it is busy, so a write immediately followed by a fetch (dirty-line eviction) is never lost.
- Sits between the cache controller/cache datapath and the off-chip/BRAM model.

Parameters:
- ramWidth, 8, data word width in bits.
- addrSize, 8, address width; array depth is 2**addrSize.
- READ_LATENCY, 3, cycles from read accept to dataReady; legal range 1..15.
- WRITE_LATENCY, 2, cycles a write occupies the array; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- RAMreadEnable  in  1  read request; may be a level held until dataReady, or a single-cycle strobe.
- RAMwriteEnable  in  1  write request strobe.
- addr  in  addrSize  request address; sampled when a request is accepted or queued.
- writeData  in  ramWidth  write data; sampled with addr.
- readData  out  ramWidth  last completed read word; holds until the next read completes.
- dataReady  out  1  one-cycle pulse; readData is valid in the same cycle.
- busy  out  1  high in any non-IDLE state.
- overrun  out  1  sticky error: a request was dropped because the pending slot was full.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0, pending slot empty.
  - readData=0, dataReady=0, busy=0, overrun=0.
  - Array contents are NOT reset.
  - Reset mid-operation aborts it; a write whose latency had not expired is not committed.
- Request qualification:
  - A request is a rising edge of its enable: enable=1 this cycle and 0 the previous cycle. The previous-cycle enable registers reset to 0.
  - A level-held RAMreadEnable therefore yields exactly one read.
- States: IDLE, WRITE_WAIT, READ_WAIT, READ_DONE.
- IDLE:
  - Write request → capture addr/writeData, counter=WRITE_LATENCY-1, go to WRITE_WAIT.
  - Read request → capture addr, counter=READ_LATENCY-1, go to READ_WAIT.
  - Simultaneous write and read → write is accepted and the read is placed in the pending slot with the same addr. Write has priority.
- WRITE_WAIT:
  - Decrement the counter.
  - When counter==0, commit array[addr]<=data on that edge, then go to IDLE, or directly launch the pending request if the slot is valid.
- READ_WAIT:
  - Decrement the counter.
  - When counter==0, on that edge: readData<=array[addr], dataReady<=1, go to READ_DONE.
  - Read latency is exactly READ_LATENCY edges after the accept edge.
- READ_DONE:
  - One cycle; dataReady=1.
  - Next edge: dataReady<=0, go to IDLE or launch the pending request.
- Read after a pending write to the same address returns the new data, because the array is sampled at completion, not at accept.
- Pending slot (one deep):
  - A qualified request seen while busy=1 is stored with its addr/data.
  - A request seen while the slot is full is dropped and sets overrun=1. overrun clears only on reset.
  - Launching from the slot and capturing a new request on the same edge is allowed: the slot is refilled.
- dataReady is never asserted for writes.
- busy is registered and equals (state != IDLE).

Decomposition:
- Shared package mem_if_pkg holds:
  - the state encoding constants (one-hot, 4 bits, matching the team's one-hot FSM style);
  - the request type codes REQ_READ=1'b0 and REQ_WRITE=1'b1 used by the pending slot;
  - latency range-check constants.
- One natural sub-module, ram_array:
  - synchronous-write/asynchronous-read word array;
  - ports clk, we, waddr, wdata, raddr, rdata;
  - swappable for a BRAM primitive.
- FSM, counter, edge detect and pending slot stay in ram_responder.

Test Plan:
- Reset, then write 0xA5 to 0x10, then RAMreadEnable held high at 0x10 with defaults → dataReady pulses exactly 3 cycles after accept with readData=0xA5, one pulse only despite the held level.
- Write 0x3C to 0x20 strobed one cycle, then a read of 0x20 the next cycle while busy → read is queued and starts the cycle after the write commits; dataReady returns 0x3C; overrun stays 0.
- Read and write asserted in the same cycle at 0x05, data 0x77, old contents 0x11 → write first, then the read returns 0x77.
- While a read is in READ_WAIT, issue two more strobed writes → the first is queued, the second is dropped; overrun=1 and stays high; the dropped address is unchanged in the array.
- Assert rst_n=0 during WRITE_WAIT of a write of 0xFF to 0x30 whose prior contents were 0x00 → outputs are 0 immediately; a later read of 0x30 returns 0x00, not 0xFF.
- READ_LATENCY=1, WRITE_LATENCY=1: back-to-back single-cycle read strobes separated by one idle cycle → each completes with dataReady on the edge after accept; no missed or duplicate pulses.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-RAM handshake: FSM state encoding,
// pending-slot request codes and the legal latency range.
package mem_if_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'b0001,
    WRITE_WAIT = 4'b0010,
    READ_WAIT  = 4'b0100,
    READ_DONE  = 4'b1000
  } state_t;

  typedef logic req_t;
  localparam req_t REQ_READ  = 1'b0;
  localparam req_t REQ_WRITE = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  function automatic logic lat_ok(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_array.sv
// Backing word array: synchronous write, asynchronous read.
// Kept behind this boundary so a BRAM primitive can be dropped in.
module ram_array #(
  parameter int ramWidth = 8,
  parameter int addrSize = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic [addrSize-1:0] waddr,
  input  logic [ramWidth-1:0] wdata,
  input  logic [addrSize-1:0] raddr,
  output logic [ramWidth-1:0] rdata
);

  logic [ramWidth-1:0] mem [2**addrSize];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder for the cache read/write strobes, with fixed read and
// write latencies and a one-deep pending slot for requests arriving while busy.
//
// state      | meaning
// IDLE       | no operation in flight, ready to accept
// WRITE_WAIT | write in flight; array written when counter reaches 0
// READ_WAIT  | read in flight; array sampled when counter reaches 0
// READ_DONE  | dataReady high for this single cycle
module ram_responder
  import mem_if_pkg::*;
#(
  parameter int ramWidth      = 8,
  parameter int addrSize      = 8,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RAMreadEnable,
  input  logic                RAMwriteEnable,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] writeData,
  output logic [ramWidth-1:0] readData,
  output logic                dataReady,
  output logic                busy,
  output logic                overrun
);

  if (!lat_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("ram_responder: READ_LATENCY must be within 1..15");
  end
  if (!lat_ok(WRITE_LATENCY)) begin : g_bad_write_latency
    $error("ram_responder: WRITE_LATENCY must be within 1..15");
  end

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [addrSize-1:0] op_addr, op_addr_n;
  logic [ramWidth-1:0] op_data, op_data_n;

  logic                pend_valid, pend_valid_n;
  req_t                pend_type, pend_type_n;
  logic [addrSize-1:0] pend_addr, pend_addr_n;
  logic [ramWidth-1:0] pend_data, pend_data_n;

  logic                rd_q, wr_q, rd_req, wr_req;
  logic [ramWidth-1:0] rdata, read_data_n;
  logic                ready_n, overrun_n;

  logic                commit, done, free;
  logic                launch, rd_taken, wr_taken;
  req_t                launch_type;
  logic [addrSize-1:0] launch_addr;
  logic [ramWidth-1:0] launch_data;

  assign rd_req = RAMreadEnable & ~rd_q;
  assign wr_req = RAMwriteEnable & ~wr_q;
  assign commit = (state == WRITE_WAIT) && (cnt == '0);

  ram_array #(
    .ramWidth (ramWidth),
    .addrSize (addrSize)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .waddr (op_addr),
    .wdata (op_data),
    .raddr (op_addr),
    .rdata (rdata)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    op_addr_n    = op_addr;
    op_data_n    = op_data;
    pend_valid_n = pend_valid;
    pend_type_n  = pend_type;
    pend_addr_n  = pend_addr;
    pend_data_n  = pend_data;
    read_data_n  = readData;
    ready_n      = 1'b0;
    overrun_n    = overrun;
    launch       = 1'b0;
    launch_type  = REQ_READ;
    launch_addr  = addr;
    launch_data  = writeData;
    rd_taken     = 1'b0;
    wr_taken     = 1'b0;
    done         = commit || (state == READ_DONE);
    free         = (state == IDLE) || done;

    case (state)
      WRITE_WAIT: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
      end
      READ_WAIT: begin
        if (cnt == '0) begin
          read_data_n = rdata;
          ready_n     = 1'b1;
          state_n     = READ_DONE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: ;
    endcase

    // A queued request always goes ahead of anything arriving on the same edge.
    if (free) begin
      if (pend_valid) begin
        launch       = 1'b1;
        launch_type  = pend_type;
        launch_addr  = pend_addr;
        launch_data  = pend_data;
        pend_valid_n = 1'b0;
      end else if (wr_req) begin
        launch      = 1'b1;
        launch_type = REQ_WRITE;
        wr_taken    = 1'b1;
        if (rd_req) begin
          pend_valid_n = 1'b1;
          pend_type_n  = REQ_READ;
          pend_addr_n  = addr;
          pend_data_n  = writeData;
          rd_taken     = 1'b1;
        end
      end else if (rd_req) begin
        launch   = 1'b1;
        rd_taken = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end

    if (launch) begin
      op_addr_n = launch_addr;
      op_data_n = launch_data;
      if (launch_type == REQ_WRITE) begin
        state_n = WRITE_WAIT;
        cnt_n   = CNT_W'(WRITE_LATENCY - 1);
      end else begin
        state_n = READ_WAIT;
        cnt_n   = CNT_W'(READ_LATENCY - 1);
      end
    end

    if (wr_req && !wr_taken) begin
      if (!pend_valid_n) begin
        pend_valid_n = 1'b1;
        pend_type_n  = REQ_WRITE;
        pend_addr_n  = addr;
        pend_data_n  = writeData;
      end else begin
        overrun_n = 1'b1;
      end
    end

    if (rd_req && !rd_taken) begin
      if (!pend_valid_n) begin
        pend_valid_n = 1'b1;
        pend_type_n  = REQ_READ;
        pend_addr_n  = addr;
        pend_data_n  = writeData;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_addr    <= '0;
      op_data    <= '0;
      pend_valid <= 1'b0;
      pend_type  <= REQ_READ;
      pend_addr  <= '0;
      pend_data  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      readData   <= '0;
      dataReady  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      op_addr    <= op_addr_n;
      op_data    <= op_data_n;
      pend_valid <= pend_valid_n;
      pend_type  <= pend_type_n;
      pend_addr  <= pend_addr_n;
      pend_data  <= pend_data_n;
      rd_q       <= RAMreadEnable;
      wr_q       <= RAMwriteEnable;
      readData   <= read_data_n;
      dataReady  <= ready_n;
      busy       <= (state_n != IDLE);
      overrun    <= overrun_n;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed per-cycle vectors for ram_responder at default latencies and at
// latency 1, including a reset that lands in the middle of a write.
module tb_ram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rd_a, wr_a, rdy_a, busy_a, ovr_a;
  logic [7:0] addr_a, wd_a, data_a;
  logic       rd_b, wr_b, rdy_b, busy_b, ovr_b;
  logic [7:0] addr_b, wd_b, data_b;

  ram_responder u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .RAMreadEnable  (rd_a),
    .RAMwriteEnable (wr_a),
    .addr           (addr_a),
    .writeData      (wd_a),
    .readData       (data_a),
    .dataReady      (rdy_a),
    .busy           (busy_a),
    .overrun        (ovr_a)
  );

  ram_responder #(
    .READ_LATENCY  (1),
    .WRITE_LATENCY (1)
  ) u_fast (
    .clk            (clk),
    .rst_n          (rst_n),
    .RAMreadEnable  (rd_b),
    .RAMwriteEnable (wr_b),
    .addr           (addr_b),
    .writeData      (wd_b),
    .readData       (data_b),
    .dataReady      (rdy_b),
    .busy           (busy_b),
    .overrun        (ovr_b)
  );

  typedef struct {
    logic       sel;     // 0: default-latency DUT, 1: latency-1 DUT
    logic       rst_b4;  // pulse reset before applying this row
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       e_rdy;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic rst_b4, input logic rd, input logic wr,
                     input logic [7:0] a, input logic [7:0] wd, input logic rdy,
                     input logic [7:0] d, input logic bsy, input logic ovr);
    vec_t v;
    v.sel = sel; v.rst_b4 = rst_b4; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd;
    v.e_rdy = rdy; v.e_data = d; v.e_busy = bsy; v.e_ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic check_reset_outputs(input int row);
    check("rst_ready_a",   row, {7'd0, rdy_a},  8'h00);
    check("rst_data_a",    row, data_a,         8'h00);
    check("rst_busy_a",    row, {7'd0, busy_a}, 8'h00);
    check("rst_overrun_a", row, {7'd0, ovr_a},  8'h00);
    check("rst_ready_b",   row, {7'd0, rdy_b},  8'h00);
    check("rst_busy_b",    row, {7'd0, busy_b}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    rd_a = 0; wr_a = 0; addr_a = 0; wd_a = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; wd_b = 0;

    // Each row: inputs applied before a posedge, outputs expected after it.
    //   sel rst rd wr addr  wdata  rdy data  busy ovr
    // write A5 to 10, then read held high: one pulse, 3 edges after accept
    add(0, 0, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 1, 8'hA5, 1, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'hA5, 0, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 0);
    // write 3C to 20, read of 20 queued behind it
    add(0, 0, 0, 1, 8'h20, 8'h3C, 0, 8'hA5, 1, 0);
    add(0, 0, 1, 0, 8'h20, 8'h00, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 0, 0);
    // 05 <= 11, then simultaneous read+write 77 at 05
    add(0, 0, 0, 1, 8'h05, 8'h11, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 0, 0);
    add(0, 0, 1, 1, 8'h05, 8'h77, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h3C, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h77, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h77, 0, 0);
    // 41 <= 99; read 10, then write 40 (queued) and write 41 (dropped)
    add(0, 0, 0, 1, 8'h41, 8'h99, 0, 8'h77, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h77, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h77, 0, 0);
    add(0, 0, 1, 0, 8'h10, 8'h00, 0, 8'h77, 1, 0);
    add(0, 0, 0, 1, 8'h40, 8'h55, 0, 8'h77, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h77, 1, 0);
    add(0, 0, 0, 1, 8'h41, 8'hEE, 1, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 0, 1);
    add(0, 0, 1, 0, 8'h41, 8'h00, 0, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hA5, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h99, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h99, 0, 1);
    add(0, 0, 1, 0, 8'h40, 8'h00, 0, 8'h99, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h99, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h99, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h55, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h55, 0, 1);
    // 30 <= 00, then FF write aborted by reset; read of 30 must give 00
    add(0, 0, 0, 1, 8'h30, 8'h00, 0, 8'h55, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h55, 1, 1);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h55, 0, 1);
    add(0, 0, 0, 1, 8'h30, 8'hFF, 0, 8'h55, 1, 1);
    add(0, 1, 1, 0, 8'h30, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    // latency-1 DUT: two writes, then read strobes one idle cycle apart
    add(1, 0, 0, 1, 8'h0A, 8'h5A, 0, 8'h00, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    add(1, 0, 0, 1, 8'h0B, 8'hB5, 0, 8'h00, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    add(1, 0, 1, 0, 8'h0A, 8'h00, 0, 8'h00, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h5A, 1, 0);
    add(1, 0, 1, 0, 8'h0B, 8'h00, 0, 8'h5A, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'hB5, 1, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'hB5, 0, 0);
    add(1, 0, 0, 0, 8'h00, 8'h00, 0, 8'hB5, 0, 0);

    repeat (2) @(negedge clk);
    check_reset_outputs(-1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst_b4) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs(i);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      if (vecs[i].sel) begin
        rd_a = 0; wr_a = 0; addr_a = 0; wd_a = 0;
        rd_b = vecs[i].rd; wr_b = vecs[i].wr; addr_b = vecs[i].addr; wd_b = vecs[i].wdata;
      end else begin
        rd_b = 0; wr_b = 0; addr_b = 0; wd_b = 0;
        rd_a = vecs[i].rd; wr_a = vecs[i].wr; addr_a = vecs[i].addr; wd_a = vecs[i].wdata;
      end
      @(negedge clk);
      if (vecs[i].sel) begin
        check("ready_b",   i, {7'd0, rdy_b},  {7'd0, vecs[i].e_rdy});
        check("data_b",    i, data_b,         vecs[i].e_data);
        check("busy_b",    i, {7'd0, busy_b}, {7'd0, vecs[i].e_busy});
        check("overrun_b", i, {7'd0, ovr_b},  {7'd0, vecs[i].e_ovr});
      end else begin
        check("ready_a",   i, {7'd0, rdy_a},  {7'd0, vecs[i].e_rdy});
        check("data_a",    i, data_a,         vecs[i].e_data);
        check("busy_a",    i, {7'd0, busy_a}, {7'd0, vecs[i].e_busy});
        check("overrun_a", i, {7'd0, ovr_a},  {7'd0, vecs[i].e_ovr});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
